descriptor_queue_arbiter: RTL

Round-robin arbiter that shares the single input-queue descriptor FIFO write port between PORT_NUM descriptor sources (host port plus network ports). Each source presents a {tsntag, bufid} descriptor with a level write request. The arbiter grants one source per cycle with fair rotation, applies FIFO almost-full backpressure, and keeps statistics counters. It sits between the per-port descriptor extractors and the input queue FIFO, in front of the TSE lookup path.

---
 rtl/descriptor_queue_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/descriptor_queue_arbiter.sv
// descriptor_queue_arbiter: round-robin arbiter sharing the input-queue FIFO write port
// between PORT_NUM descriptor sources, with almost-full backpressure and statistics.
`default_nettype none

module descriptor_queue_arbiter #(
  parameter int PORT_NUM    = 4,
  parameter int TAG_WIDTH   = 48,
  parameter int BUFID_WIDTH = 9
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [PORT_NUM*TAG_WIDTH-1:0]      iv_tsntag,
  input  logic [PORT_NUM*BUFID_WIDTH-1:0]    iv_bufid,
  input  logic [PORT_NUM-1:0]                iv_descriptor_wr,
  output logic [PORT_NUM-1:0]                ov_descriptor_ack,
  input  logic                               i_fifo_almost_full,
  output logic [TAG_WIDTH+BUFID_WIDTH-1:0]   ov_fifo_wdata,
  output logic                               o_fifo_wr,
  output logic [15:0]                        ov_desc_cnt,
  output logic [15:0]                        ov_stall_cnt
);

  localparam int PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int DW    = TAG_WIDTH + BUFID_WIDTH;

  typedef enum logic [0:0] {
    IDLE_S  = 1'b0,
    STALL_S = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PORT_NUM-1:0] r_served_mask;

  logic [PORT_NUM-1:0] w_elig;
  logic                w_found;
  logic [PTR_W-1:0]    w_winner;
  logic [PORT_NUM-1:0] w_win_oh;
  logic [DW-1:0]       w_win_data;
  logic                w_grant;
  logic                w_stall_inc;

  // A port that was granted stays masked until its request is seen low once.
  assign w_elig = iv_descriptor_wr & ~r_served_mask;

  // Search order starts at the rotating pointer and wraps around the ports.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_win_oh   = '0;
    w_win_data = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if (!w_found && w_elig[p] && (((int'(r_rr_ptr) + i) % PORT_NUM) == p)) begin
          w_found     = 1'b1;
          w_winner    = PTR_W'(p);
          w_win_oh[p] = 1'b1;
          w_win_data  = {iv_tsntag[p*TAG_WIDTH +: TAG_WIDTH],
                         iv_bufid[p*BUFID_WIDTH +: BUFID_WIDTH]};
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_stall_inc = 1'b0;
    case (r_state)
      IDLE_S: begin
        if (w_found) begin
          if (i_fifo_almost_full) begin
            w_state_nxt = STALL_S;
          end else begin
            w_grant = 1'b1;
          end
        end
      end
      STALL_S: begin
        w_stall_inc = 1'b1;
        if (!i_fifo_almost_full) begin
          w_state_nxt = IDLE_S;
        end
      end
      default: begin
        w_state_nxt = IDLE_S;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state           <= IDLE_S;
      r_rr_ptr          <= '0;
      r_served_mask     <= '0;
      ov_descriptor_ack <= '0;
      ov_fifo_wdata     <= '0;
      o_fifo_wr         <= 1'b0;
      ov_desc_cnt       <= '0;
      ov_stall_cnt      <= '0;
    end else begin
      r_state           <= w_state_nxt;
      r_served_mask     <= (r_served_mask & iv_descriptor_wr) | (w_grant ? w_win_oh : '0);
      ov_descriptor_ack <= w_grant ? w_win_oh : '0;
      ov_fifo_wdata     <= w_grant ? w_win_data : '0;
      o_fifo_wr         <= w_grant;
      if (w_grant) begin
        r_rr_ptr    <= (w_winner == PTR_W'(PORT_NUM - 1)) ? '0 : w_winner + PTR_W'(1);
        ov_desc_cnt <= ov_desc_cnt + 16'd1;
      end
      if (w_stall_inc && (ov_stall_cnt != 16'hFFFF)) begin
        ov_stall_cnt <= ov_stall_cnt + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire
